// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg: default constants and prescaler period helper for the switch debouncer
// Exports SW_WIDTH, CLK_50_HZ, DEBOUNCE_SAMPLE_HZ, DEBOUNCE_STABLE and calc_period().
package switch_debouncer_pkg;

    localparam int SW_WIDTH           = 18;
    localparam int CLK_50_HZ          = 50000000;
    localparam int DEBOUNCE_SAMPLE_HZ = 1000;
    localparam int DEBOUNCE_STABLE    = 4;

    function automatic int calc_period(input int clk_hz, input int sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: one-bit synchronizer, sample history and level acceptance
// Ports: Clock_50 clock, Resetn async active-low reset, tick sample strobe,
//        sw_i raw switch bit, db_o debounced bit, chg_o one-cycle change flag.
module debounce_cell
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_SAMPLES = DEBOUNCE_STABLE
) (
    input  logic Clock_50,
    input  logic Resetn,
    input  logic tick,
    input  logic sw_i,
    output logic db_o,
    output logic chg_o
);

    logic                      s1_q, s2_q, db_q, db_d, chg_q, chg_d;
    logic [STABLE_SAMPLES-1:0] hist_q, hist_d;

    // Only a full run of identical samples moves the output; mixed history holds it.
    always_comb begin
        hist_d = tick ? {hist_q[STABLE_SAMPLES-2:0], s2_q} : hist_q;
        db_d   = !tick ? db_q : (&hist_d) ? 1'b1 : (~|hist_d) ? 1'b0 : db_q;
        chg_d  = db_d ^ db_q;
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= '0;
            db_q   <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            s1_q   <= sw_i;
            s2_q   <= s1_q;
            hist_q <= hist_d;
            db_q   <= db_d;
            chg_q  <= chg_d;
        end
    end

    assign db_o  = db_q;
    assign chg_o = chg_q;

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: debounces a vector of toggle switches for the encoder/display path
// Ports: Clock_50 clock, Resetn async active-low reset, SWITCH_I raw switches,
//        SWITCH_DB_O debounced switches, CHANGE_O one-cycle any-bit change pulse,
//        SAMPLE_TICK_O one-cycle prescaler tick, RISE_O/FALL_O per-bit edge pulses
//        (only when DEBOUNCE_EDGE_EN is defined).
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH          = SW_WIDTH,
    parameter int CLK_FREQ_HZ    = CLK_50_HZ,
    parameter int SAMPLE_HZ      = DEBOUNCE_SAMPLE_HZ,
    parameter int STABLE_SAMPLES = DEBOUNCE_STABLE
) (
    input  logic             Clock_50,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] SWITCH_I,
    output logic [WIDTH-1:0] SWITCH_DB_O,
    output logic             CHANGE_O,
    output logic             SAMPLE_TICK_O
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] RISE_O,
    output logic [WIDTH-1:0] FALL_O
`endif
);

    localparam int PERIOD = calc_period(CLK_FREQ_HZ, SAMPLE_HZ);
    localparam int CW     = $clog2(PERIOD);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tick, sample_tick_q, sample_tick_d;
    logic [WIDTH-1:0] db, chg;

    always_comb begin
        tick          = cnt_q == CW'(PERIOD - 1);
        cnt_d         = tick ? '0 : cnt_q + CW'(1);
        sample_tick_d = tick;
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q         <= '0;
            sample_tick_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            sample_tick_q <= sample_tick_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        debounce_cell #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_cell (
            .Clock_50 (Clock_50),
            .Resetn   (Resetn),
            .tick     (tick),
            .sw_i     (SWITCH_I[i]),
            .db_o     (db[i]),
            .chg_o    (chg[i])
        );
    end

    assign SWITCH_DB_O   = db;
    assign CHANGE_O      = |chg;
    assign SAMPLE_TICK_O = sample_tick_q;

`ifdef DEBOUNCE_EDGE_EN
    // Decoded purely from flop outputs, so edges line up with CHANGE_O.
    assign RISE_O = db & chg;
    assign FALL_O = ~db & chg;
`endif

endmodule
